// File: rtl/multicycle_controller_if.sv
// ----------------------------------------------------------------------------
// multicycle_controller_if
// Purpose : groups the instruction fields, ALU flags, memory handshake and
//           datapath control strobes exchanged between the multicycle
//           controller and its datapath/memory.
// Modports: master - controller side (reads IR fields/flags/mem_ready,
//                    drives strobes, selects, mem_timeout, state_o)
//           slave  - datapath side (mirror of master)
// Signals : Opcode[6:0], funct3[2:0], Zero, Negflag, Unsigned_less_than,
//           mem_ready, IRWrite, PCWrite, AdrSrc, MemRead, MemWrite, RegWrite,
//           ALUSrcA[1:0], ALUSrcB[1:0], ResultSrc[1:0], ALUOp[1:0],
//           ImmSrc[2:0], Loadtype[2:0], Storetype[1:0], mem_timeout,
//           state_o[3:0]
// ----------------------------------------------------------------------------
interface multicycle_controller_if;
    logic [6:0] Opcode;
    logic [2:0] funct3;
    logic       Zero;
    logic       Negflag;
    logic       Unsigned_less_than;
    logic       mem_ready;

    logic       IRWrite;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ALUOp;
    logic [2:0] ImmSrc;
    logic [2:0] Loadtype;
    logic [1:0] Storetype;
    logic       mem_timeout;
    logic [3:0] state_o;

    modport master (
        input  Opcode, funct3, Zero, Negflag, Unsigned_less_than, mem_ready,
        output IRWrite, PCWrite, AdrSrc, MemRead, MemWrite, RegWrite,
        output ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc, Loadtype, Storetype,
        output mem_timeout, state_o
    );

    modport slave (
        output Opcode, funct3, Zero, Negflag, Unsigned_less_than, mem_ready,
        input  IRWrite, PCWrite, AdrSrc, MemRead, MemWrite, RegWrite,
        input  ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc, Loadtype, Storetype,
        input  mem_timeout, state_o
    );
endinterface

// File: rtl/multicycle_controller.sv
// ----------------------------------------------------------------------------
// multicycle_controller
// Purpose : RV32I multicycle control FSM with memory wait handling and a
//           stall timeout.
// Ports   : clk  - clock, rising edge
//           rst  - asynchronous active-high reset
//           bus  - multicycle_controller_if.master (IR fields, ALU flags,
//                  mem_ready in; datapath strobes, selects, mem_timeout,
//                  state_o out)
// Params  : MAX_WAIT - stalled cycles tolerated before mem_timeout
//           CNT_W    - wait counter width, 2**CNT_W > MAX_WAIT
// Config  : define RV_ILLEGAL_TRAP_EN to send undefined opcodes to a TRAP
//           state (state_o = 4'hF) that holds until reset; otherwise an
//           undefined opcode returns to FETCH as a no-op.
// ----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_controller_if.master bus
);

    localparam logic [3:0] S_FETCH  = 4'h0;
    localparam logic [3:0] S_DECODE = 4'h1;
    localparam logic [3:0] S_MEMADR = 4'h2;
    localparam logic [3:0] S_MEMRD  = 4'h3;
    localparam logic [3:0] S_MEMWB  = 4'h4;
    localparam logic [3:0] S_MEMWR  = 4'h5;
    localparam logic [3:0] S_EXR    = 4'h6;
    localparam logic [3:0] S_EXI    = 4'h7;
    localparam logic [3:0] S_ALUWB  = 4'h8;
    localparam logic [3:0] S_BRANCH = 4'h9;
    localparam logic [3:0] S_JAL    = 4'hA;
    localparam logic [3:0] S_JALR   = 4'hB;
    localparam logic [3:0] S_LUI    = 4'hC;
    localparam logic [3:0] S_AUIPC  = 4'hD;
`ifdef RV_ILLEGAL_TRAP_EN
    localparam logic [3:0] S_TRAP   = 4'hF;
`endif

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       wait_st_c;
    logic       timeout_c;
    logic       taken_c;
    logic [2:0] ltype_c;
    logic [1:0] stype_c;

    logic       ir_write_c, pc_write_c, adr_src_c;
    logic       mem_read_c, mem_write_c, reg_write_c;
    logic [1:0] alu_src_a_c, alu_src_b_c, result_src_c, alu_op_c;
    logic [2:0] imm_src_c;

    // State and wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stall timeout; a completion on the saturating cycle wins over timeout
    assign wait_st_c = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timeout_c = wait_st_c && !bus.mem_ready && (cnt_q == CNT_W'(MAX_WAIT));

    // Counter is zero outside wait states, so every entry into one starts at 0
    always_comb begin
        cnt_d = '0;
        if (wait_st_c && !bus.mem_ready && !timeout_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Branch condition from funct3 and ALU flags
    always_comb begin
        taken_c = 1'b0;
        case (bus.funct3)
            3'b000:  taken_c = bus.Zero;
            3'b001:  taken_c = !bus.Zero;
            3'b100:  taken_c = bus.Negflag;
            3'b101:  taken_c = !bus.Negflag;
            3'b110:  taken_c = bus.Unsigned_less_than;
            3'b111:  taken_c = !bus.Unsigned_less_than;
            default: taken_c = 1'b0;
        endcase
    end

    // Load/store width decode; unknown funct3 falls back to word
    always_comb begin
        ltype_c = 3'b000;
        stype_c = 2'b10;
        case (bus.funct3)
            3'b000:  ltype_c = 3'b010;
            3'b001:  ltype_c = 3'b001;
            3'b100:  ltype_c = 3'b100;
            3'b101:  ltype_c = 3'b011;
            default: ltype_c = 3'b000;
        endcase
        case (bus.funct3)
            3'b000:  stype_c = 2'b00;
            3'b001:  stype_c = 2'b01;
            default: stype_c = 2'b10;
        endcase
    end

    // Next state and control outputs
    always_comb begin
        state_d      = state_q;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        adr_src_c    = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        reg_write_c  = 1'b0;
        alu_src_a_c  = 2'b00;
        alu_src_b_c  = 2'b00;
        result_src_c = 2'b00;
        alu_op_c     = 2'b00;
        imm_src_c    = 3'b000;

        case (state_q)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b10;
                ir_write_c  = bus.mem_ready;
                pc_write_c  = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b01;
                imm_src_c   = 3'b010;
                case (bus.Opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXR;
                    OP_I:              state_d = S_EXI;
                    OP_B:              state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
`ifdef RV_ILLEGAL_TRAP_EN
                    default:           state_d = S_TRAP;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                imm_src_c   = (bus.Opcode == OP_STORE) ? 3'b001 : 3'b000;
                state_d     = (bus.Opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read_c = 1'b1;
                adr_src_c  = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout_c) begin
                    state_d = S_FETCH;
                end
            end
            S_MEMWB: begin
                reg_write_c  = 1'b1;
                result_src_c = 2'b01;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                mem_write_c = 1'b1;
                adr_src_c   = 1'b1;
                if (bus.mem_ready || timeout_c) begin
                    state_d = S_FETCH;
                end
            end
            S_EXR: begin
                alu_src_a_c = 2'b10;
                alu_op_c    = 2'b11;
                state_d     = S_ALUWB;
            end
            S_EXI: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                alu_op_c    = 2'b10;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_c = 2'b10;
                alu_op_c    = 2'b01;
                imm_src_c   = 3'b010;
                pc_write_c  = taken_c;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a_c  = 2'b01;
                alu_src_b_c  = 2'b01;
                imm_src_c    = 3'b011;
                reg_write_c  = 1'b1;
                result_src_c = 2'b10;
                pc_write_c   = 1'b1;
                state_d      = S_FETCH;
            end
            S_JALR: begin
                alu_src_a_c  = 2'b10;
                alu_src_b_c  = 2'b01;
                reg_write_c  = 1'b1;
                result_src_c = 2'b10;
                pc_write_c   = 1'b1;
                state_d      = S_FETCH;
            end
            S_LUI: begin
                imm_src_c    = 3'b100;
                reg_write_c  = 1'b1;
                result_src_c = 2'b11;
                state_d      = S_FETCH;
            end
            S_AUIPC: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b01;
                imm_src_c   = 3'b100;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
`ifdef RV_ILLEGAL_TRAP_EN
            S_TRAP: begin
                state_d = S_TRAP;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Outputs are forced low while rst is high, independent of the clock
    assign bus.IRWrite     = !rst && ir_write_c;
    assign bus.PCWrite     = !rst && pc_write_c;
    assign bus.AdrSrc      = !rst && adr_src_c;
    assign bus.MemRead     = !rst && mem_read_c;
    assign bus.MemWrite    = !rst && mem_write_c;
    assign bus.RegWrite    = !rst && reg_write_c;
    assign bus.mem_timeout = !rst && timeout_c;
    assign bus.ALUSrcA     = rst ? 2'b00  : alu_src_a_c;
    assign bus.ALUSrcB     = rst ? 2'b00  : alu_src_b_c;
    assign bus.ResultSrc   = rst ? 2'b00  : result_src_c;
    assign bus.ALUOp       = rst ? 2'b00  : alu_op_c;
    assign bus.ImmSrc      = rst ? 3'b000 : imm_src_c;
    assign bus.Loadtype    = rst ? 3'b000 : ltype_c;
    assign bus.Storetype   = rst ? 2'b00  : stype_c;
    assign bus.state_o     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// ----------------------------------------------------------------------------
// tb_multicycle_controller
// Purpose : directed, table-driven bench for multicycle_controller plus
//           hand-written sequences for stalls, timeout, illegal opcode and
//           reset during a store. Honours RV_ILLEGAL_TRAP_EN like the RTL.
// ----------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam int K_NONE  = 0;
    localparam int K_ALUOP = 1;
    localparam int K_SRC   = 2;
    localparam int K_RES   = 3;
    localparam int K_IMM   = 4;

    localparam int NVEC = 31;

    // exp = {state, IRWrite, PCWrite, MemRead, MemWrite, RegWrite, mem_timeout, Loadtype, Storetype}
    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [3:0] fl;     // {Zero, Negflag, Unsigned_less_than, mem_ready}
        logic [14:0] exp;
        int         kind;
        logic [3:0] sel;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    multicycle_controller_if bus ();

    multicycle_controller #(
        .MAX_WAIT (15),
        .CNT_W    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input string name, input logic [6:0] op, input logic [2:0] f3,
                                input logic [3:0] fl, input logic [3:0] st, input logic [5:0] strb,
                                input logic [4:0] ls, input int kind, input logic [3:0] sel);
        vec_t v;
        v.name = name;
        v.op   = op;
        v.f3   = f3;
        v.fl   = fl;
        v.exp  = {st, strb, ls};
        v.kind = kind;
        v.sel  = sel;
        return v;
    endfunction

    function automatic logic [14:0] obs();
        return {bus.state_o, bus.IRWrite, bus.PCWrite, bus.MemRead, bus.MemWrite,
                bus.RegWrite, bus.mem_timeout, bus.Loadtype, bus.Storetype};
    endfunction

    function automatic logic [3:0] sel_obs(input int kind);
        case (kind)
            K_ALUOP: return {2'b00, bus.ALUOp};
            K_SRC:   return {bus.ALUSrcA, bus.ALUSrcB};
            K_RES:   return {2'b00, bus.ResultSrc};
            K_IMM:   return {1'b0, bus.ImmSrc};
            default: return 4'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    vec_t vec [NVEC];
    int   to_idx;
    logic saw_to;

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Strobe patterns {IRWrite, PCWrite, MemRead, MemWrite, RegWrite, mem_timeout}
        // Load/store widths {Loadtype, Storetype}: f3 000 -> 010_00, 001 -> 001_01,
        // 100 -> 100_10, 010 -> 000_10
        vec[0]  = mk("add_fetch_stall", OP_R, 3'b000, 4'b0000, 4'h0, 6'b001000, 5'b01000, K_NONE,  4'h0);
        vec[1]  = mk("add_fetch",       OP_R, 3'b000, 4'b0001, 4'h0, 6'b111000, 5'b01000, K_NONE,  4'h0);
        vec[2]  = mk("add_decode",      OP_R, 3'b000, 4'b0001, 4'h1, 6'b000000, 5'b01000, K_SRC,   4'b0101);
        vec[3]  = mk("add_exr",         OP_R, 3'b000, 4'b0001, 4'h6, 6'b000000, 5'b01000, K_ALUOP, 4'b0011);
        vec[4]  = mk("add_aluwb",       OP_R, 3'b000, 4'b0001, 4'h8, 6'b000010, 5'b01000, K_RES,   4'b0000);
        vec[5]  = mk("beq_fetch",       OP_B, 3'b000, 4'b0001, 4'h0, 6'b111000, 5'b01000, K_NONE,  4'h0);
        vec[6]  = mk("beq_decode",      OP_B, 3'b000, 4'b0001, 4'h1, 6'b000000, 5'b01000, K_NONE,  4'h0);
        vec[7]  = mk("beq_nt_branch",   OP_B, 3'b000, 4'b0001, 4'h9, 6'b000000, 5'b01000, K_ALUOP, 4'b0001);
        vec[8]  = mk("bne_fetch",       OP_B, 3'b001, 4'b0001, 4'h0, 6'b111000, 5'b00101, K_NONE,  4'h0);
        vec[9]  = mk("bne_decode",      OP_B, 3'b001, 4'b0001, 4'h1, 6'b000000, 5'b00101, K_NONE,  4'h0);
        vec[10] = mk("bne_t_branch",    OP_B, 3'b001, 4'b0001, 4'h9, 6'b010000, 5'b00101, K_ALUOP, 4'b0001);
        vec[11] = mk("blt_fetch",       OP_B, 3'b100, 4'b0101, 4'h0, 6'b111000, 5'b10010, K_NONE,  4'h0);
        vec[12] = mk("blt_decode",      OP_B, 3'b100, 4'b0101, 4'h1, 6'b000000, 5'b10010, K_NONE,  4'h0);
        vec[13] = mk("blt_t_branch",    OP_B, 3'b100, 4'b0101, 4'h9, 6'b010000, 5'b10010, K_NONE,  4'h0);
        vec[14] = mk("b010_fetch",      OP_B, 3'b010, 4'b1111, 4'h0, 6'b111000, 5'b00010, K_NONE,  4'h0);
        vec[15] = mk("b010_decode",     OP_B, 3'b010, 4'b1111, 4'h1, 6'b000000, 5'b00010, K_NONE,  4'h0);
        vec[16] = mk("b010_nt_branch",  OP_B, 3'b010, 4'b1111, 4'h9, 6'b000000, 5'b00010, K_NONE,  4'h0);
        vec[17] = mk("addi_fetch",      OP_I, 3'b000, 4'b0001, 4'h0, 6'b111000, 5'b01000, K_NONE,  4'h0);
        vec[18] = mk("addi_decode",     OP_I, 3'b000, 4'b0001, 4'h1, 6'b000000, 5'b01000, K_NONE,  4'h0);
        vec[19] = mk("addi_exi",        OP_I, 3'b000, 4'b0001, 4'h7, 6'b000000, 5'b01000, K_ALUOP, 4'b0010);
        vec[20] = mk("addi_aluwb",      OP_I, 3'b000, 4'b0001, 4'h8, 6'b000010, 5'b01000, K_NONE,  4'h0);
        vec[21] = mk("sh_fetch",    OP_STORE, 3'b001, 4'b0001, 4'h0, 6'b111000, 5'b00101, K_NONE,  4'h0);
        vec[22] = mk("sh_decode",   OP_STORE, 3'b001, 4'b0001, 4'h1, 6'b000000, 5'b00101, K_NONE,  4'h0);
        vec[23] = mk("sh_memadr",   OP_STORE, 3'b001, 4'b0001, 4'h2, 6'b000000, 5'b00101, K_IMM,   4'b0001);
        vec[24] = mk("sh_memwr",    OP_STORE, 3'b001, 4'b0001, 4'h5, 6'b000100, 5'b00101, K_NONE,  4'h0);
        vec[25] = mk("lui_fetch",     OP_LUI, 3'b000, 4'b0001, 4'h0, 6'b111000, 5'b01000, K_NONE,  4'h0);
        vec[26] = mk("lui_decode",    OP_LUI, 3'b000, 4'b0001, 4'h1, 6'b000000, 5'b01000, K_NONE,  4'h0);
        vec[27] = mk("lui_exec",      OP_LUI, 3'b000, 4'b0001, 4'hC, 6'b000010, 5'b01000, K_RES,   4'b0011);
        vec[28] = mk("jal_fetch",     OP_JAL, 3'b000, 4'b0001, 4'h0, 6'b111000, 5'b01000, K_NONE,  4'h0);
        vec[29] = mk("jal_decode",    OP_JAL, 3'b000, 4'b0001, 4'h1, 6'b000000, 5'b01000, K_NONE,  4'h0);
        vec[30] = mk("jal_exec",      OP_JAL, 3'b000, 4'b0001, 4'hA, 6'b010010, 5'b01000, K_RES,   4'b0010);

        // Reset state: outputs low even with mem_ready high in FETCH
        rst                    = 1'b1;
        bus.Opcode             = OP_R;
        bus.funct3             = 3'b000;
        bus.Zero               = 1'b0;
        bus.Negflag            = 1'b0;
        bus.Unsigned_less_than = 1'b0;
        bus.mem_ready          = 1'b1;
        #2;
        check("reset_state", 32'(obs() >> 5), 32'h0);
        do_reset();

        // Table-driven instruction walk
        for (int i = 0; i < NVEC; i++) begin
            bus.Opcode             = vec[i].op;
            bus.funct3             = vec[i].f3;
            bus.Zero               = vec[i].fl[3];
            bus.Negflag            = vec[i].fl[2];
            bus.Unsigned_less_than = vec[i].fl[1];
            bus.mem_ready          = vec[i].fl[0];
            #1;
            check(vec[i].name, 32'(obs()), 32'(vec[i].exp));
            if (vec[i].kind != K_NONE) begin
                check({vec[i].name, "_sel"}, 32'(sel_obs(vec[i].kind)), 32'(vec[i].sel));
            end
            step();
        end

        // lw with three stalled cycles in MEMRD
        bus.Opcode    = OP_LOAD;
        bus.funct3    = 3'b010;
        bus.Zero      = 1'b0;
        bus.Negflag   = 1'b0;
        bus.Unsigned_less_than = 1'b0;
        bus.mem_ready = 1'b1;
        step();
        step();
        step();
        saw_to = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.mem_ready = (k == 3);
            #1;
            if (k == 0) begin
                check("lw_memrd_entry", 32'({bus.state_o, bus.MemRead, bus.AdrSrc, bus.Loadtype}),
                      32'({4'h3, 1'b1, 1'b1, 3'b000}));
            end
            saw_to = saw_to | bus.mem_timeout;
            step();
        end
        #1;
        check("lw_memwb_at_4", 32'({bus.state_o, bus.RegWrite, bus.ResultSrc}),
              32'({4'h4, 1'b1, 2'b01}));
        check("lw_no_timeout", 32'(saw_to), 32'h0);
        step();
        check("lw_back_fetch", 32'(bus.state_o), 32'h0);

        // Fetch stall until timeout, then saturating-with-ready completion
        do_reset();
        bus.Opcode    = OP_R;
        bus.mem_ready = 1'b0;
        to_idx        = -1;
        for (int k = 0; k < 40 && to_idx < 0; k++) begin
            #1;
            if (bus.mem_timeout === 1'b1) to_idx = k;
            step();
        end
        check("fetch_timeout_cycle", 32'(to_idx), 32'd15);
        #1;
        check("after_timeout", 32'({bus.state_o, bus.mem_timeout, bus.MemRead}),
              32'({4'h0, 1'b0, 1'b1}));
        repeat (15) step();
        bus.mem_ready = 1'b1;
        #1;
        check("sat_with_ready", 32'({bus.mem_timeout, bus.IRWrite, bus.PCWrite}), 32'b011);
        step();
        check("sat_to_decode", 32'(bus.state_o), 32'h1);

        // Undefined opcode
        do_reset();
        bus.Opcode    = 7'h7F;
        bus.mem_ready = 1'b1;
        step();
        #1;
        check("illegal_decode", 32'(bus.state_o), 32'h1);
        step();
        #1;
`ifdef RV_ILLEGAL_TRAP_EN
        check("trap_enter", 32'({bus.state_o, bus.IRWrite, bus.PCWrite, bus.MemRead,
                                 bus.MemWrite, bus.RegWrite}), 32'({4'hF, 5'b00000}));
        repeat (5) step();
        check("trap_hold", 32'({bus.state_o, bus.PCWrite, bus.MemWrite, bus.RegWrite}),
              32'({4'hF, 3'b000}));
        do_reset();
        #1;
        check("trap_reset_exit", 32'(bus.state_o), 32'h0);
`else
        check("illegal_nop", 32'({bus.state_o, bus.MemRead}), 32'({4'h0, 1'b1}));
`endif

        // Reset asserted mid-cycle while a store waits in MEMWR
        do_reset();
        bus.Opcode    = OP_STORE;
        bus.funct3    = 3'b010;
        bus.mem_ready = 1'b1;
        step();
        step();
        bus.mem_ready = 1'b0;
        step();
        #1;
        check("memwr_wait", 32'({bus.state_o, bus.MemWrite}), 32'({4'h5, 1'b1}));
        #2;
        rst = 1'b1;
        #2;
        check("rst_in_memwr", 32'({bus.state_o, bus.MemWrite, bus.RegWrite, bus.MemRead,
                                   bus.mem_timeout}), 32'h0);
        step();
        check("rst_held", 32'({bus.state_o, bus.MemWrite, bus.RegWrite}), 32'h0);
        rst = 1'b0;
        #1;
        check("rst_release", 32'({bus.state_o, bus.MemRead, bus.MemWrite}),
              32'({4'h0, 1'b1, 1'b0}));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
